// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word reads to instruction memory and buffers the
// returned words with their PCs for decode. A redirect flushes buffered/in-flight work.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = CW1'(FIFO_DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    cnt_t        outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
    ptr_t        wr_q, wr_d, rd_q, rd_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q [FIFO_DEPTH];
    logic [31:0] pc_q   [FIFO_DEPTH];

    logic        pop, req_v, fire, keep;
    logic [CW:0] used;

    always_comb begin
        pop   = valid_q && instr_ready;
        used  = {1'b0, cnt_q} + {1'b0, outst_q};
        // Credits: buffered plus in-flight words may never exceed the FIFO,
        // counting the slot freed by a pop this cycle.
        req_v = reset_n && !redirect_valid && (used < DEPTH_W + CW1'(pop));
        fire  = req_v && imem_req_ready;
        keep  = imem_rsp_valid && !redirect_valid && (drop_q == '0);

        outst_d    = outst_q + cnt_t'(fire) - cnt_t'(imem_rsp_valid);
        fetch_pc_d = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        cnt_d      = cnt_q + cnt_t'(keep) - cnt_t'(pop);
        wr_d       = wr_q + ptr_t'(keep);
        rd_d       = rd_q + ptr_t'(pop);
        drop_d     = (imem_rsp_valid && drop_q != '0) ? drop_q - cnt_t'(1) : drop_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            cnt_d      = '0;
            rd_d       = wr_q;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outst_q - cnt_t'(imem_rsp_valid);
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            if (keep) begin
                word_q[wr_q] <= imem_rsp_data;
                pc_q[wr_q]   <= rsp_pc_q;
            end
        end
    end

    assign imem_req_valid = req_v;
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = valid_q;
    assign instr          = word_q[rd_q];
    assign instr_pc       = pc_q[rd_q];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order latency memory model plus a
// reference of the expected fetch/decode PC streams.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;

    instruction_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t mq[$];

    int nassert = 0, nfail = 0, cyc_n = 0, lat = 1, fires = 0, pops = 0;
    logic rdy = 1'b1, mrdy = 1'b1, redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] exp_fetch = RPC, exp_pc = RPC;
    logic s_rv, s_iv;
    logic [31:0] s_ra, s_ipc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nassert++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, sample at the falling edge, update the model.
    task automatic cyc();
        logic fire;
        imem_req_ready = mrdy;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        s_rv = imem_req_valid; s_ra = imem_req_addr;
        s_iv = instr_valid;    s_ipc = instr_pc;
        if (redir) chk("no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
        if (instr_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, memf(exp_pc));
            if (rdy) begin exp_pc += 32'd4; pops++; end
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        fire = imem_req_valid && mrdy;
        if (fire) begin
            mq.push_back('{imem_req_addr, cyc_n + lat});
            exp_fetch += 32'd4;
            fires++;
            chk("outstanding_bound", 32'(mq.size() <= DEPTH), 32'd1);
        end
        if (redir) begin
            exp_fetch = rpc & ~32'd3;
            exp_pc    = rpc & ~32'd3;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir = 1'b1; rpc = pc;
        cyc();
        redir = 1'b0;
    endtask

    initial begin
        int k;
        logic [31:0] a0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // First fetch and 2-cycle fill with 1-cycle memory
        cyc();
        chk("first_req_valid", {31'b0, s_rv}, 32'd1);
        chk("first_req_addr", s_ra, RPC);
        chk("fill_iv_c0", {31'b0, s_iv}, 32'd0);
        cyc(); chk("fill_iv_c1", {31'b0, s_iv}, 32'd0);
        cyc(); chk("fill_iv_c2", {31'b0, s_iv}, 32'd1);
        chk("fill_pc_c2", s_ipc, RPC);

        // Streaming throughput
        pops = 0;
        repeat (20) cyc();
        chk("stream_pops", pops, 32'd20);

        // Backpressure from an empty buffer
        rdy = 1'b0;
        redirect_to(32'h0000_0400);
        fires = 0;
        repeat (10) cyc();
        chk("bp_fires", fires, DEPTH);
        chk("bp_req_valid", {31'b0, s_rv}, 32'd0);
        chk("bp_head_pc", s_ipc, 32'h0000_0400);
        rdy = 1'b1;
        repeat (10) cyc();

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        k = 0;
        while (mq.size() != 2 && k < 12) begin cyc(); k++; end
        chk("two_in_flight", mq.size(), 32'd2);
        redirect_to(32'h0000_2002);
        k = 0;
        do begin cyc(); k++; end while (!s_iv && k < 20);
        chk("redir_first_valid", {31'b0, s_iv}, 32'd1);
        chk("redir_first_pc", s_ipc, 32'h0000_2000);
        repeat (8) cyc();

        // Redirect coinciding with a response and a pop, 1-cycle memory
        lat = 1;
        repeat (6) cyc();
        chk("coinc_pre_rsp", {31'b0, imem_rsp_valid}, 32'd1);
        redirect_to(32'h0000_3000);
        chk("coinc_pop_valid", {31'b0, s_iv}, 32'd1);
        cyc(); chk("coinc_empty_r1", {31'b0, s_iv}, 32'd0);
        cyc(); chk("coinc_empty_r2", {31'b0, s_iv}, 32'd0);
        cyc(); chk("coinc_valid_r3", {31'b0, s_iv}, 32'd1);
        chk("coinc_pc_r3", s_ipc, 32'h0000_3000);
        repeat (4) cyc();

        // Memory stall
        mrdy = 1'b0;
        a0 = exp_fetch;
        fires = 0;
        repeat (5) begin
            cyc();
            chk("stall_addr", s_ra, a0);
        end
        chk("stall_fires", fires, 32'd0);
        mrdy = 1'b1;
        repeat (6) cyc();

        // PC wrap
        redirect_to(32'hFFFF_FFFE);
        cyc();
        chk("wrap_req0", s_ra, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_req1", s_ra, 32'h0000_0000);
        repeat (6) cyc();

        // Randomized traffic
        repeat (400) begin
            rdy  = 1'($urandom_range(0, 1));
            mrdy = ($urandom_range(0, 3) != 0);
            lat  = int'($urandom_range(1, 4));
            if ($urandom_range(0, 31) == 0) redirect_to($urandom);
            else cyc();
        end
        rdy = 1'b1; mrdy = 1'b1; lat = 1;
        repeat (15) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
